// File: rtl/key_event_arbiter.sv
// rtl/key_event_arbiter.sv - per-key press/hold timers merged round-robin onto one event stream
module key_event_arbiter #(
  parameter int N_KEYS        = 4,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  localparam int IDW          = $clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_down,
  input  logic [N_KEYS-1:0] key_dnedge,
  input  logic [N_KEYS-1:0] key_upedge,
  input  logic              repeat_en,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [IDW-1:0]    evt_key,
  output logic [1:0]        evt_type,
  output logic              overflow
);

  localparam logic [1:0] T_PRESS   = 2'd0;
  localparam logic [1:0] T_RELEASE = 2'd1;
  localparam logic [1:0] T_LONG    = 2'd2;
  localparam logic [1:0] T_REPEAT  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RPT} key_state_e;

  key_state_e              state_q [N_KEYS];
  key_state_e              state_d [N_KEYS];
  logic [31:0]             cnt_q   [N_KEYS];
  logic [31:0]             cnt_d   [N_KEYS];
  logic [N_KEYS-1:0][3:0]  pend_q, pend_d, post, grant;
  logic [N_KEYS-1:0]       cand;
  logic [IDW-1:0]          rr_q, rr_d, win;
  logic [1:0]              win_type;
  logic                    found, take, load;
  logic                    evt_valid_q, evt_valid_d;
  logic [IDW-1:0]          evt_key_q, evt_key_d;
  logic [1:0]              evt_type_q, evt_type_d;
  logic                    overflow_q, overflow_d;

  // Release edge is checked before the timer so a release on the expiry cycle suppresses LONG/REPEAT.
  always_comb begin
    for (int k = 0; k < N_KEYS; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      post[k]    = 4'b0000;
      case (state_q[k])
        S_IDLE: begin
          if (key_dnedge[k]) begin
            post[k][T_PRESS] = 1'b1;
            cnt_d[k]         = '0;
            state_d[k]       = S_HOLD;
          end
        end
        S_HOLD, S_RPT: begin
          if (key_upedge[k]) begin
            post[k][T_RELEASE] = 1'b1;
            cnt_d[k]           = '0;
            state_d[k]         = S_IDLE;
          end else if (!key_down[k]) begin
            cnt_d[k]   = '0;
            state_d[k] = S_IDLE;
          end else if (state_q[k] == S_HOLD) begin
            if (cnt_q[k] == 32'(LONG_CYCLES - 1)) begin
              post[k][T_LONG] = 1'b1;
              cnt_d[k]        = '0;
              state_d[k]      = S_RPT;
            end else begin
              cnt_d[k] = cnt_q[k] + 32'd1;
            end
          end else begin
            if (cnt_q[k] == 32'(REPEAT_CYCLES - 1)) begin
              post[k][T_REPEAT] = repeat_en;
              cnt_d[k]          = '0;
            end else begin
              cnt_d[k] = cnt_q[k] + 32'd1;
            end
          end
        end
        default: state_d[k] = S_IDLE;
      endcase
    end
  end

  // Scanning downward lets the lowest offset from rr_q overwrite earlier hits.
  always_comb begin
    for (int k = 0; k < N_KEYS; k++) cand[k] = |pend_q[k];
    found = 1'b0;
    win   = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (cand[(int'(rr_q) + i) % N_KEYS]) begin
        found = 1'b1;
        win   = IDW'((int'(rr_q) + i) % N_KEYS);
      end
    end
    if (pend_q[win][T_PRESS])       win_type = T_PRESS;
    else if (pend_q[win][T_LONG])   win_type = T_LONG;
    else if (pend_q[win][T_REPEAT]) win_type = T_REPEAT;
    else                            win_type = T_RELEASE;
  end

  always_comb begin
    take        = !evt_valid_q || evt_ready;
    load        = take && found;
    grant       = '0;
    evt_valid_d = evt_valid_q;
    evt_key_d   = evt_key_q;
    evt_type_d  = evt_type_q;
    rr_d        = rr_q;
    if (load) begin
      grant[win][win_type] = 1'b1;
      evt_valid_d          = 1'b1;
      evt_key_d            = win;
      evt_type_d           = win_type;
      rr_d                 = IDW'((int'(win) + 1) % N_KEYS);
    end else if (take) begin
      evt_valid_d = 1'b0;
    end
    // A post landing on a bit being granted the same cycle is not a drop.
    pend_d     = (pend_q & ~grant) | post;
    overflow_d = overflow_q | (|(post & pend_q & ~grant));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_KEYS; k++) begin
        state_q[k] <= S_IDLE;
        cnt_q[k]   <= '0;
      end
      pend_q      <= '0;
      rr_q        <= '0;
      evt_valid_q <= 1'b0;
      evt_key_q   <= '0;
      evt_type_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      for (int k = 0; k < N_KEYS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      pend_q      <= pend_d;
      rr_q        <= rr_d;
      evt_valid_q <= evt_valid_d;
      evt_key_q   <= evt_key_d;
      evt_type_q  <= evt_type_d;
      overflow_q  <= overflow_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_key   = evt_key_q;
  assign evt_type  = evt_type_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// tb/tb_key_event_arbiter.sv - directed bench for key_event_arbiter with an accepted-event log
module tb_key_event_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_down, key_dnedge, key_upedge;
  logic       repeat_en, evt_valid, evt_ready, overflow;
  logic [1:0] evt_key, evt_type;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0;
  int q_key[$];
  int q_type[$];
  int q_cyc[$];

  localparam int PRESS = 0, RELEASE = 1, LONG = 2, REPEAT = 3;

  key_event_arbiter #(.N_KEYS(4), .LONG_CYCLES(8), .REPEAT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_down(key_down), .key_dnedge(key_dnedge),
    .key_upedge(key_upedge), .repeat_en(repeat_en), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_key(evt_key), .evt_type(evt_type), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      q_key.push_back(int'(evt_key));
      q_type.push_back(int'(evt_type));
      q_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_key.delete();
    q_type.delete();
    q_cyc.delete();
  endtask

  task automatic expect_ev(input string tc, input int i, input int key, input int typ, input int at);
    if (i >= q_key.size()) begin
      check($sformatf("%s_ev%0d_missing", tc, i), q_key.size(), i + 1);
    end else begin
      check($sformatf("%s_ev%0d_key", tc, i), q_key[i], key);
      check($sformatf("%s_ev%0d_type", tc, i), q_type[i], typ);
      check($sformatf("%s_ev%0d_cyc", tc, i), q_cyc[i] - t0, at);
    end
  endtask

  initial begin
    rst_n = 1'b0; key_down = '0; key_dnedge = '0; key_upedge = '0;
    repeat_en = 1'b1; evt_ready = 1'b1;
    step(3);
    check("rst_valid", evt_valid, 0);
    check("rst_key", evt_key, 0);
    check("rst_type", evt_type, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    step(2);

    // 1: press, long, repeats, release on key2
    clear_log(); t0 = cyc;
    key_dnedge = 4'b0100; key_down = 4'b0100;
    step(1); key_dnedge = '0;
    step(19);
    key_upedge = 4'b0100; key_down = '0;
    step(1); key_upedge = '0;
    step(10);
    check("t1_count", q_key.size(), 5);
    expect_ev("t1", 0, 2, PRESS, 2);
    expect_ev("t1", 1, 2, LONG, 10);
    expect_ev("t1", 2, 2, REPEAT, 14);
    expect_ev("t1", 3, 2, REPEAT, 18);
    expect_ev("t1", 4, 2, RELEASE, 22);
    check("t1_overflow", overflow, 0);

    // 2: bring rr_ptr to 2 via a key1 tap, then three simultaneous presses
    clear_log(); t0 = cyc;
    key_dnedge = 4'b0010; key_down = 4'b0010;
    step(1); key_dnedge = '0; key_down = '0;
    step(4);
    check("t2_tap_count", q_key.size(), 1);
    expect_ev("t2tap", 0, 1, PRESS, 2);
    clear_log(); t0 = cyc;
    key_dnedge = 4'b1011; key_down = 4'b1011;
    step(1); key_dnedge = '0;
    step(3); key_down = '0;
    step(5);
    check("t2_count", q_key.size(), 3);
    expect_ev("t2", 0, 3, PRESS, 2);
    expect_ev("t2", 1, 0, PRESS, 3);
    expect_ev("t2", 2, 1, PRESS, 4);

    // 4: repeat disabled, key0 held 30 cycles
    repeat_en = 1'b0;
    clear_log(); t0 = cyc;
    key_dnedge = 4'b0001; key_down = 4'b0001;
    step(1); key_dnedge = '0;
    step(29);
    key_upedge = 4'b0001; key_down = '0;
    step(1); key_upedge = '0;
    step(6);
    check("t4_count", q_key.size(), 3);
    expect_ev("t4", 0, 0, PRESS, 2);
    expect_ev("t4", 1, 0, LONG, 10);
    expect_ev("t4", 2, 0, RELEASE, 32);

    // 5: release lands on the LONG expiry cycle
    repeat_en = 1'b1;
    clear_log(); t0 = cyc;
    key_dnedge = 4'b0010; key_down = 4'b0010;
    step(1); key_dnedge = '0;
    step(7);
    key_upedge = 4'b0010; key_down = '0;
    step(1); key_upedge = '0;
    step(5);
    check("t5_count", q_key.size(), 2);
    expect_ev("t5", 0, 1, PRESS, 2);
    expect_ev("t5", 1, 1, RELEASE, 10);
    check("t5_overflow", overflow, 0);

    // 3: consumer stalled while key1 is held
    evt_ready = 1'b0;
    key_dnedge = 4'b0010; key_down = 4'b0010;
    step(1); key_dnedge = '0;
    for (int i = 2; i <= 31; i++) begin
      step(1);
      check($sformatf("t3_valid_e%0d", i), evt_valid, 1);
      check($sformatf("t3_key_e%0d", i), evt_key, 1);
      check($sformatf("t3_type_e%0d", i), evt_type, PRESS);
      check($sformatf("t3_ovf_e%0d", i), overflow, (i >= 17) ? 1 : 0);
    end
    key_upedge = 4'b0010; key_down = '0; evt_ready = 1'b1;
    step(1); key_upedge = '0;
    step(8);
    check("t3_ovf_sticky", overflow, 1);
    check("t3_drained", evt_valid, 0);

    // 6: async reset while an event is being held
    evt_ready = 1'b0;
    key_dnedge = 4'b0100; key_down = 4'b0100;
    step(1); key_dnedge = '0;
    step(3);
    check("t6_pre_valid", evt_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", evt_valid, 0);
    check("t6_rst_overflow", overflow, 0);
    check("t6_rst_key", evt_key, 0);
    step(2);
    key_down = '0; evt_ready = 1'b1; rst_n = 1'b1;
    clear_log();
    step(20);
    check("t6_no_stale", q_key.size(), 0);
    check("t6_idle", evt_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
